sevenseg_bcd_encoder: RTL and testbench
=======================================

// Module: sevenseg_bcd_encoder
// PURPOSE
//  Inverse of the BCD-to-7-segment decoder. Receives 7-segment patterns as a
//  serial bit stream, maps each pattern back to its BCD digit, and packs
//  DIGITS digits into one word. The word is presented on a valid/ready output.
//  Used to read back and check the segment drive of the display path.
// PARAMETERS
//  DIGITS       4   digits per frame; bcd_out width is 4*DIGITS
//  BIT_TIMEOUT  16  idle cycles allowed mid-frame before the partial frame is dropped (>=2)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  seg_valid  in   1         seg_bit is valid this cycle
//  seg_bit    in   1         segment bit; per digit order a,b,c,d,e,f,g; 1 = lit
//  seg_ready  out  1         bit accepted when seg_valid & seg_ready
//  bcd_out    out  4*DIGITS  packed digits; first-received digit in MS nibble
//  err        out  1         >=1 digit in bcd_out was not a legal 0-9 pattern
//  out_valid  out  1         bcd_out/err valid; held until out_ready
//  out_ready  in   1         consumer accepts word when out_valid & out_ready
//  timeout    out  1         1-cycle pulse: partial frame discarded
// BEHAVIOUR
//  Reset (async, any time, mid-frame included): state=IDLE, all counters 0,
//   bcd_out=0, err=0, out_valid=0, timeout=0; seg_ready=1 from first clock after release.
//  Legal patterns {a..g}: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B (hex).
//   Any other pattern decodes to 4'hF and sets that digit's invalid flag.
//  States:
//   IDLE  : seg_ready=1; accepted bit -> shift into seg_sr, bit_cnt=1, go SHIFT.
//   SHIFT : seg_ready=1; each accepted bit shifts in, bit_cnt++.
//           7th bit of a digit: decode {seg_sr,seg_bit} in the same cycle, store the
//           nibble in slot dig_cnt, bit_cnt=0, dig_cnt++.
//           If that was the last digit, go HOLD.
//   HOLD  : seg_ready=0, out_valid=1; bcd_out/err stable.
//           out_ready=1 -> out_valid=0 and go IDLE next cycle.
//  Latency: out_valid rises the cycle after the last bit of the last digit is accepted.
//  err = OR of the frame's invalid flags; it is cleared when a new frame starts.
//  Backpressure: seg_valid in HOLD is not accepted. The source holds the bit.
//   Same cycle as out_ready: handshake completes, bit still not accepted;
//   seg_ready=1 on the next cycle.
//  Timeout: in SHIFT, idle_cnt counts consecutive cycles with no accepted bit and
//   clears on each accepted bit. At idle_cnt==BIT_TIMEOUT: discard the partial frame
//   (counters 0, slots unchanged, out_valid stays 0), pulse timeout for 1 cycle, go IDLE.
//   No timeout in IDLE or HOLD.
//  bcd_out holds its last value between frames. Slots are only overwritten by new digits.
//  Widths: bit_cnt 3b (0-6), dig_cnt $clog2(DIGITS+1), idle_cnt $clog2(BIT_TIMEOUT+1).
// STRUCTURE
//  Package sevenseg_pkg:
//   - SEG_W=7, BCD_W=4, BCD_INVALID=4'hF
//   - segment pattern constants SEG_0..SEG_9
//   - state enum {IDLE,SHIFT,HOLD}
//  Sub-module seg7_to_bcd: combinational 7b pattern -> {invalid, 4b digit} lookup,
//   reusable against the forward decoder in checks.
//  Top holds the FSM, shift register, counters and output slots.
// TESTING
//  1 DIGITS=4, send 30,6D,79,33 (digits 1,2,3,4), out_ready=1
//    -> bcd_out=16'h1234, err=0, out_valid high 1 cycle after 28th accepted bit.
//  2 Send 7E,7F,7B,5B with out_ready=0 for 5 cycles
//    -> out_valid, bcd_out=16'h0895 stable 5 cycles; seg_ready=0 throughout HOLD.
//  3 Digit 2 pattern=01 (illegal) -> bcd_out=16'hxFxx slot = F, err=1.
//    Next legal frame -> err=0.
//  4 Stop after 10 bits for 16 cycles -> timeout pulse exactly once, out_valid stays 0.
//    Next 28 bits decode as a fresh frame.
//  5 Assert rst_n low after 15 bits (mid-cycle) -> outputs 0 immediately.
//    A following full frame decodes correctly.
//  6 seg_valid held during HOLD with out_ready asserted
//    -> that bit is accepted only on the cycle after the handshake; no bit lost or duplicated.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants for the 7-segment readback path: widths, legal segment
// patterns ({a,b,c,d,e,f,g}, a in the MSB) and the encoder state type.
package sevenseg_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational lookup from a 7-segment pattern back to its BCD digit;
// anything outside the ten legal glyphs maps to BCD_INVALID with invalid_o set.
module seg7_to_bcd
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             invalid_o
);

    always_comb begin
        bcd_o     = BCD_INVALID;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_bcd_encoder.sv
// Deserialises 7-segment patterns bit by bit, decodes each back to BCD and
// presents DIGITS digits as one word on a valid/ready output.
module sevenseg_bcd_encoder
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int BIT_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seg_valid,
    input  logic                seg_bit,
    output logic                seg_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                timeout
);

    localparam int DW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(BIT_TIMEOUT + 1);
    localparam logic [DW-1:0] LAST_DIG   = DW'(DIGITS - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(BIT_TIMEOUT - 1);

    state_e           state_q;
    logic [SEG_W-2:0] segSr_q;
    logic [2:0]       bitCnt_q;
    logic [DW-1:0]    digCnt_q;
    logic [IW-1:0]    idleCnt_q;
    logic [BCD_W-1:0] slot_q [DIGITS];
    logic             err_q;
    logic             outValid_q;
    logic             segReady_q;
    logic             timeout_q;

    logic             accept_d;
    logic [SEG_W-1:0] pattern_d;
    logic [BCD_W-1:0] digit_d;
    logic             invalid_d;

    assign accept_d  = seg_valid & segReady_q;
    assign pattern_d = {segSr_q, seg_bit};

    // The 7th bit bypasses the shift register so the digit lands in its slot this cycle.
    seg7_to_bcd u_decode (
        .seg_i     (pattern_d),
        .bcd_o     (digit_d),
        .invalid_o (invalid_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            segSr_q    <= '0;
            bitCnt_q   <= '0;
            digCnt_q   <= '0;
            idleCnt_q  <= '0;
            for (int i = 0; i < DIGITS; i++) slot_q[i] <= '0;
            err_q      <= 1'b0;
            outValid_q <= 1'b0;
            segReady_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    segReady_q <= 1'b1;
                    if (accept_d) begin
                        segSr_q   <= {segSr_q[SEG_W-3:0], seg_bit};
                        bitCnt_q  <= 3'd1;
                        idleCnt_q <= '0;
                        err_q     <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept_d) begin
                        idleCnt_q <= '0;
                        if (bitCnt_q == 3'd6) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                if (digCnt_q == DW'(i)) slot_q[i] <= digit_d;
                            end
                            err_q    <= err_q | invalid_d;
                            bitCnt_q <= '0;
                            if (digCnt_q == LAST_DIG) begin
                                digCnt_q   <= '0;
                                outValid_q <= 1'b1;
                                segReady_q <= 1'b0;
                                state_q    <= HOLD;
                            end else begin
                                digCnt_q <= digCnt_q + 1'b1;
                            end
                        end else begin
                            segSr_q  <= {segSr_q[SEG_W-3:0], seg_bit};
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end else if (idleCnt_q == IDLE_LIMIT) begin
                        // Stalled source: drop the partial frame, slots keep their old digits.
                        idleCnt_q <= '0;
                        bitCnt_q  <= '0;
                        digCnt_q  <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        idleCnt_q <= idleCnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        segReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bcd_out = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_out[BCD_W*(DIGITS-1-i) +: BCD_W] = slot_q[i];
        end
    end

    assign seg_ready = segReady_q;
    assign err       = err_q;
    assign out_valid = outValid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sevenseg_bcd_encoder.sv
// Scoreboard bench: frames are pushed as expected words when sent, and a
// negedge monitor checks the DUT word on every output handshake.
module tb_sevenseg_bcd_encoder;

    localparam int DIGITS      = 4;
    localparam int BIT_TIMEOUT = 16;
    localparam int WW          = 4 * DIGITS;
    localparam logic [6:0] LEGAL [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                          7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    typedef struct packed {
        logic [WW-1:0] word;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          seg_valid;
    logic          seg_bit;
    logic          seg_ready;
    logic [WW-1:0] bcd_out;
    logic          err;
    logic          out_valid;
    logic          out_ready;
    logic          timeout;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   hsCount     = 0;
    int   expectHs    = 0;
    int   timeoutCount = 0;
    int   expTimeouts = 0;
    int   lastHoldLen = 0;
    int   readyMode   = 0;
    int   holdCycles  = 0;

    sevenseg_bcd_encoder #(.DIGITS(DIGITS), .BIT_TIMEOUT(BIT_TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_valid (seg_valid),
        .seg_bit   (seg_bit),
        .seg_ready (seg_ready),
        .bcd_out   (bcd_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: find the pattern among the ten legal glyphs, else 0xF and invalid.
    function automatic logic [4:0] refDecode(input logic [6:0] p);
        for (int d = 0; d < 10; d++) begin
            if (p == LEGAL[d]) return {1'b0, 4'(d)};
        end
        return {1'b1, 4'hF};
    endfunction

    function automatic logic [6:0] genPattern(input bit allowIllegal);
        if (allowIllegal && $urandom_range(0, 7) == 0) return 7'($urandom);
        return LEGAL[$urandom_range(0, 9)];
    endfunction

    // Consumer side: always ready, random, or stalled for holdCycles of each HOLD.
    always @(posedge clk) begin
        int left;
        #1;
        case (readyMode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (!out_valid) begin
                    left      = holdCycles;
                    out_ready = 1'b0;
                end else if (left > 0) begin
                    out_ready = 1'b0;
                    left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: scoreboard compare on handshakes plus timing rules around HOLD.
    always @(negedge clk) begin
        static int   frameBits = 0;
        static bit   expectValidNext = 1'b0;
        static bit   prevOutValid = 1'b0;
        static bit   checkAfterHs = 1'b0;
        static int   holdLen = 0;
        bit          expNow;
        exp_t        e;
        if (!rst_n) begin
            frameBits       = 0;
            expectValidNext = 1'b0;
            prevOutValid    = 1'b0;
            checkAfterHs    = 1'b0;
        end else begin
            expNow          = expectValidNext;
            expectValidNext = 1'b0;
            if (expNow) checkOutput("validLatency", 32'(out_valid), 32'd1);
            else if (!prevOutValid) checkOutput("validEarly", 32'(out_valid), 32'd0);
            if (checkAfterHs) begin
                checkOutput("readyAfterHandshake", 32'(seg_ready), 32'd1);
                checkOutput("validAfterHandshake", 32'(out_valid), 32'd0);
                checkAfterHs = 1'b0;
            end
            if (timeout) begin
                timeoutCount++;
                frameBits = 0;
            end
            if (out_valid) begin
                holdLen = prevOutValid ? holdLen + 1 : 1;
                checkOutput("segReadyInHold", 32'(seg_ready), 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWord", 32'({err, bcd_out}), 32'hFFFFFFFF);
                end else begin
                    e = expQ[0];
                    checkOutput("holdWord", 32'({err, bcd_out}), 32'({e.err, e.word}));
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        hsCount++;
                        lastHoldLen  = holdLen;
                        checkAfterHs = 1'b1;
                    end
                end
            end
            if (seg_valid && seg_ready) begin
                frameBits++;
                if (frameBits == 7 * DIGITS) begin
                    expectValidNext = 1'b1;
                    frameBits       = 0;
                end
            end
            prevOutValid = out_valid;
        end
    end

    task automatic idleCycles(input int n);
        seg_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBit(input logic b);
        bit accepted = 1'b0;
        int waited   = 0;
        seg_valid = 1'b1;
        seg_bit   = b;
        while (!accepted && waited < 500) begin
            @(negedge clk);
            if (seg_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!accepted) checkOutput("bitAccept", 32'(accepted), 32'd1);
        seg_valid = 1'b0;
    endtask

    task automatic sendBits(input logic [6:0] p, input int n);
        for (int b = 6; b > 6 - n; b--) sendBit(p[b]);
    endtask

    task automatic applyStimulus(input logic [6:0] pats [DIGITS], input int gapMax, input int longGapBit);
        exp_t       e;
        logic [4:0] r;
        int         idx = 0;
        e.word = '0;
        e.err  = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            r      = refDecode(pats[d]);
            e.word = {e.word[WW-5:0], r[3:0]};
            e.err  = e.err | r[4];
        end
        expQ.push_back(e);
        expectHs++;
        for (int d = 0; d < DIGITS; d++) begin
            for (int b = 6; b >= 0; b--) begin
                sendBit(pats[d][b]);
                idx++;
                if (idx < 7 * DIGITS) begin
                    if (idx == longGapBit) idleCycles(BIT_TIMEOUT - 1);
                    else idleCycles($urandom_range(0, gapMax));
                end
            end
        end
    endtask

    task automatic waitHandshakes();
        int n = 0;
        while (hsCount < expectHs && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("handshakeWait", 32'(hsCount), 32'(expectHs));
    endtask

    initial begin
        logic [6:0] pats [DIGITS];
        int         t0;
        rst_n     = 1'b1;
        seg_valid = 1'b0;
        seg_bit   = 1'b0;
        readyMode = 0;
        #2 rst_n = 1'b0;
        #2;
        checkOutput("resetWord", 32'({err, bcd_out}), 32'd0);
        checkOutput("resetFlags", 32'({out_valid, timeout, seg_ready}), 32'd0);
        #23 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyBeforeClock", 32'(seg_ready), 32'd0);
        @(negedge clk);
        checkOutput("readyAfterRelease", 32'(seg_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] frame 1234, consumer always ready");
        pats = '{7'h30, 7'h6D, 7'h79, 7'h33};
        applyStimulus(pats, 0, -1);
        waitHandshakes();
        checkOutput("holdLenReady", 32'(lastHoldLen), 32'd1);

        $display("[TB] frame 0895, consumer stalls 5 cycles");
        readyMode  = 2;
        holdCycles = 5;
        pats = '{7'h7E, 7'h7F, 7'h7B, 7'h5B};
        applyStimulus(pats, 0, -1);
        waitHandshakes();
        checkOutput("holdLenStall", 32'(lastHoldLen), 32'd6);

        $display("[TB] illegal digit then clean frame");
        readyMode = 0;
        pats = '{7'h30, 7'h01, 7'h79, 7'h33};
        applyStimulus(pats, 1, -1);
        pats = '{7'h5F, 7'h70, 7'h7E, 7'h7F};
        applyStimulus(pats, 1, -1);
        waitHandshakes();

        $display("[TB] partial frame timeout, then fresh frame");
        t0 = timeoutCount;
        sendBits(7'h33, 7);
        sendBits(7'h5B, 3);
        idleCycles(BIT_TIMEOUT + 2);
        expTimeouts++;
        checkOutput("timeoutPulses", 32'(timeoutCount - t0), 32'd1);
        pats = '{7'h79, 7'h6D, 7'h30, 7'h7E};
        applyStimulus(pats, 0, -1);
        waitHandshakes();

        $display("[TB] gap one short of the timeout keeps the frame");
        t0 = timeoutCount;
        pats = '{7'h5B, 7'h33, 7'h70, 7'h6D};
        applyStimulus(pats, 0, 11);
        waitHandshakes();
        checkOutput("noTimeoutShortGap", 32'(timeoutCount - t0), 32'd0);

        $display("[TB] reset mid-frame");
        sendBits(genPattern(1'b0), 7);
        sendBits(genPattern(1'b0), 7);
        sendBits(7'h7F, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetWord", 32'({err, bcd_out}), 32'd0);
        checkOutput("midResetFlags", 32'({out_valid, timeout, seg_ready}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("readyAfterMidReset", 32'(seg_ready), 32'd1);
        @(posedge clk);
        #1;
        pats = '{7'h7B, 7'h5B, 7'h33, 7'h79};
        applyStimulus(pats, 0, -1);
        waitHandshakes();

        $display("[TB] next frame queued behind a stalled HOLD");
        readyMode  = 2;
        holdCycles = 3;
        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < DIGITS; d++) pats[d] = genPattern(1'b0);
            applyStimulus(pats, 0, -1);
        end
        waitHandshakes();

        $display("[TB] randomized frames");
        readyMode = 1;
        for (int f = 0; f < 25; f++) begin
            for (int d = 0; d < DIGITS; d++) pats[d] = genPattern(1'b1);
            applyStimulus(pats, 3, -1);
        end
        waitHandshakes();

        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        checkOutput("timeoutTotal", 32'(timeoutCount), 32'(expTimeouts));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
